// File: rtl/line_cmd_if.sv
// Line command bus between line_scheduler and inlinecontrol.
// master: drives per-lane start addresses, line length, flags and the
//         one-cycle valid strobe; samples ds_ready (inlinecontrol working).
// slave : the inlinecontrol side of the same bus.
interface line_cmd_if #(
    parameter int unsigned X_MAC        = 4,
    parameter int unsigned ADDR_LEN     = 13,
    parameter int unsigned MAX_LINE_LEN = 10
);
    logic [ADDR_LEN*X_MAC-1:0] st_addr;
    logic [MAX_LINE_LEN-1:0]   linelen;
    logic                      linealign;
    logic                      ispad;
    logic                      tofifo;
    logic                      fromfifo;
    logic                      valid;
    logic                      ds_ready;

    modport master (
        output st_addr, linelen, linealign, ispad, tofifo, fromfifo, valid,
        input  ds_ready
    );

    modport slave (
        input  st_addr, linelen, linealign, ispad, tofifo, fromfifo, valid,
        output ds_ready
    );
endinterface

// File: rtl/line_scheduler.sv
// line_scheduler: walks the input rows of one layer and issues one line
// command per row to inlinecontrol, never while inlinecontrol is working.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             one-cycle pulse, latches cfg_* (accepted only in IDLE)
//   cfg_*             layer configuration (base, strides, line count, flags)
//   cmd (master)      line command bus: st_addr, linelen, flags, valid, ds_ready
//   busy              state is not IDLE
//   done              one-cycle pulse at layer completion
//   err               sticky illegal-configuration flag, cleared by next start
//   line_idx          index of the current or last issued row
module line_scheduler #(
    parameter int unsigned X_MAC         = 4,
    parameter int unsigned ADDR_LEN      = 13,
    parameter int unsigned MAX_LINE_LEN  = 10,
    parameter int unsigned MAX_LINES_LEN = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_LEN-1:0]      cfg_base,
    input  logic [ADDR_LEN-1:0]      cfg_row_stride,
    input  logic [ADDR_LEN-1:0]      cfg_mac_stride,
    input  logic [MAX_LINES_LEN-1:0] cfg_num_lines,
    input  logic [MAX_LINE_LEN-1:0]  cfg_linelen,
    input  logic                     cfg_ispad,
    input  logic                     cfg_linealign,
    input  logic                     cfg_tofifo,
    input  logic                     cfg_fromfifo,
    line_cmd_if.master               cmd,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [MAX_LINES_LEN-1:0] line_idx
);

    typedef enum logic [2:0] {IDLE, ISSUE, ACK, WAIT, FIN} state_t;

    state_t state_q, state_d;

    logic [ADDR_LEN-1:0]       row_stride_q, row_stride_d;
    logic [ADDR_LEN-1:0]       mac_stride_q, mac_stride_d;
    logic [MAX_LINES_LEN-1:0]  num_lines_q,  num_lines_d;
    logic [MAX_LINE_LEN-1:0]   len_cfg_q,    len_cfg_d;
    logic                      ispad_cfg_q,  ispad_cfg_d;
    logic                      align_cfg_q,  align_cfg_d;
    logic                      tof_cfg_q,    tof_cfg_d;
    logic                      fromf_cfg_q,  fromf_cfg_d;
    logic [ADDR_LEN-1:0]       cur_addr_q,   cur_addr_d;

    logic [ADDR_LEN*X_MAC-1:0] st_addr_q,    st_addr_d;
    logic [MAX_LINE_LEN-1:0]   linelen_q,    linelen_d;
    logic                      ispad_q,      ispad_d;
    logic                      linealign_q,  linealign_d;
    logic                      tofifo_q,     tofifo_d;
    logic                      fromfifo_q,   fromfifo_d;
    logic                      valid_q,      valid_d;
    logic                      busy_d, done_d, err_d;
    logic [MAX_LINES_LEN-1:0]  line_idx_d;

    always_comb begin
        state_d      = state_q;
        row_stride_d = row_stride_q;
        mac_stride_d = mac_stride_q;
        num_lines_d  = num_lines_q;
        len_cfg_d    = len_cfg_q;
        ispad_cfg_d  = ispad_cfg_q;
        align_cfg_d  = align_cfg_q;
        tof_cfg_d    = tof_cfg_q;
        fromf_cfg_d  = fromf_cfg_q;
        cur_addr_d   = cur_addr_q;
        st_addr_d    = st_addr_q;
        linelen_d    = linelen_q;
        ispad_d      = ispad_q;
        linealign_d  = linealign_q;
        tofifo_d     = tofifo_q;
        fromfifo_d   = fromfifo_q;
        valid_d      = 1'b0;
        done_d       = 1'b0;
        err_d        = err;
        line_idx_d   = line_idx;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    row_stride_d = cfg_row_stride;
                    mac_stride_d = cfg_mac_stride;
                    num_lines_d  = cfg_num_lines;
                    len_cfg_d    = cfg_linelen;
                    ispad_cfg_d  = cfg_ispad;
                    align_cfg_d  = cfg_linealign;
                    tof_cfg_d    = cfg_tofifo;
                    fromf_cfg_d  = cfg_fromfifo;
                    err_d        = 1'b0;
                    if (cfg_num_lines == '0) begin
                        state_d = FIN;
                    end else if (cfg_linelen < MAX_LINE_LEN'(4)) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        line_idx_d = '0;
                        cur_addr_d = cfg_base;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!cmd.ds_ready) begin
                    valid_d = 1'b1;
                    for (int unsigned j = 0; j < X_MAC; j++) begin
                        st_addr_d[j*ADDR_LEN +: ADDR_LEN] =
                            cur_addr_q + ADDR_LEN'(j) * mac_stride_q;
                    end
                    linelen_d   = len_cfg_q;
                    ispad_d     = ispad_cfg_q;
                    linealign_d = align_cfg_q;
                    tofifo_d    = tof_cfg_q && (line_idx != num_lines_q - 1'b1);
                    fromfifo_d  = fromf_cfg_q && (line_idx != '0);
                    state_d     = ACK;
                end
            end
            // inlinecontrol raises working one edge after it samples valid,
            // so ds_ready is not yet meaningful here.
            ACK: state_d = WAIT;
            WAIT: begin
                if (!cmd.ds_ready) begin
                    if (line_idx == num_lines_q - 1'b1) begin
                        state_d = FIN;
                    end else begin
                        line_idx_d = line_idx + 1'b1;
                        cur_addr_d = cur_addr_q + row_stride_q;
                        state_d    = ISSUE;
                    end
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_stride_q <= '0;
            mac_stride_q <= '0;
            num_lines_q  <= '0;
            len_cfg_q    <= '0;
            ispad_cfg_q  <= 1'b0;
            align_cfg_q  <= 1'b0;
            tof_cfg_q    <= 1'b0;
            fromf_cfg_q  <= 1'b0;
            cur_addr_q   <= '0;
            st_addr_q    <= '0;
            linelen_q    <= '0;
            ispad_q      <= 1'b0;
            linealign_q  <= 1'b0;
            tofifo_q     <= 1'b0;
            fromfifo_q   <= 1'b0;
            valid_q      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            line_idx     <= '0;
        end else begin
            state_q      <= state_d;
            row_stride_q <= row_stride_d;
            mac_stride_q <= mac_stride_d;
            num_lines_q  <= num_lines_d;
            len_cfg_q    <= len_cfg_d;
            ispad_cfg_q  <= ispad_cfg_d;
            align_cfg_q  <= align_cfg_d;
            tof_cfg_q    <= tof_cfg_d;
            fromf_cfg_q  <= fromf_cfg_d;
            cur_addr_q   <= cur_addr_d;
            st_addr_q    <= st_addr_d;
            linelen_q    <= linelen_d;
            ispad_q      <= ispad_d;
            linealign_q  <= linealign_d;
            tofifo_q     <= tofifo_d;
            fromfifo_q   <= fromfifo_d;
            valid_q      <= valid_d;
            busy         <= busy_d;
            done         <= done_d;
            err          <= err_d;
            line_idx     <= line_idx_d;
        end
    end

    assign cmd.st_addr   = st_addr_q;
    assign cmd.linelen   = linelen_q;
    assign cmd.ispad     = ispad_q;
    assign cmd.linealign = linealign_q;
    assign cmd.tofifo    = tofifo_q;
    assign cmd.fromfifo  = fromfifo_q;
    assign cmd.valid     = valid_q;

endmodule

// File: doc/line_scheduler.md
Name: line_scheduler

Overview:
- Upstream command generator for inlinecontrol; walks one layer's input rows in the line buffer.
- For each row, issues one line command: per-MAC start addresses, linelen, ispad, linealign, tofifo, fromfifo and a one-cycle valid.
- Never asserts valid while inlinecontrol is working, so a line in progress is never truncated.

Parameters:
- X_MAC, 4, number of MAC lanes, one start address per lane.
- ADDR_LEN, 13, buffer address width.
- MAX_LINE_LEN, 10, width of linelen.
- MAX_LINES_LEN, 10, width of the line count and line index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  one-cycle pulse; latches all cfg_* inputs; ignored unless IDLE.
- cfg_base  in  ADDR_LEN  lane-0 address of row 0.
- cfg_row_stride  in  ADDR_LEN  address step between consecutive rows.
- cfg_mac_stride  in  ADDR_LEN  address offset between adjacent lanes.
- cfg_num_lines  in  MAX_LINES_LEN  rows to issue.
- cfg_linelen  in  MAX_LINE_LEN  line length; legal values are 4 or more.
- cfg_ispad, cfg_linealign, cfg_tofifo, cfg_fromfifo  in  1 each  per-layer flags.
- ds_ready  in  1  inlinecontrol ready, i.e. its working flag.
- st_addr  out  ADDR_LEN*X_MAC  lane j occupies bits [j*ADDR_LEN +: ADDR_LEN].
- linelen  out  MAX_LINE_LEN  to inlinecontrol.
- linealign, ispad, tofifo, fromfifo  out  1 each  to inlinecontrol.
- valid  out  1  line command strobe.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the layer completes.
- err  out  1  sticky; set on an illegal configuration, cleared by the next accepted start.
- line_idx  out  MAX_LINES_LEN  index of the current or last issued row.

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk.
  - All outputs reset to 0 and state goes to IDLE.
  - Reset mid-layer aborts immediately; no further valid is issued.
- All outputs are registered.
- Every command field is stable from the cycle valid rises until the next valid.
- FSM states: IDLE, ISSUE, ACK, WAIT, FIN.
- IDLE:
  - On start, latch the configuration and clear err.
  - If cfg_num_lines==0, go to FIN.
  - If cfg_linelen<4, set err and go to FIN; no valid is issued.
  - Otherwise set line_idx=0 and cur_addr=cfg_base, then go to ISSUE.
- ISSUE, when ds_ready==0:
  - Register valid=1.
  - st_addr lane j = (cur_addr + j*cfg_mac_stride) mod 2^ADDR_LEN.
  - linelen, ispad and linealign are taken from the latched configuration.
  - tofifo = cfg_tofifo AND (line_idx != num_lines-1).
  - fromfifo = cfg_fromfifo AND (line_idx != 0).
  - Go to ACK.
- ISSUE, when ds_ready==1: stall there.
- ACK:
  - valid<=0; unconditionally go to WAIT.
  - ds_ready is stale for exactly this one cycle, because inlinecontrol registers working one edge after it samples valid.
- WAIT, when ds_ready==0:
  - If line_idx==num_lines-1, go to FIN.
  - Otherwise line_idx+1 and cur_addr+=cfg_row_stride (wraps mod 2^ADDR_LEN), then go to ISSUE.
- WAIT, when ds_ready==1: hold.
- FIN: done=1 for one cycle; next state IDLE, where busy=0.
- Latency:
  - Start sampled at edge e0 gives the first valid high after e1 (ds_ready==0).
  - ds_ready falling gives the next valid 2 cycles later.
  - done follows 2 cycles after the final ds_ready fall.
- valid is never high for 2 consecutive cycles.
- valid is never asserted while ds_ready==1 is sampled in ISSUE.
- start while busy is ignored; the latched configuration is unchanged.
- Changes on cfg_* inputs after start have no effect until the next layer.
- A start pulse coinciding with the FIN cycle is ignored; start must arrive in IDLE.
- Widths:
  - Address sums truncate to ADDR_LEN.
  - j*cfg_mac_stride is computed at ADDR_LEN width.
  - No saturation on any address arithmetic.

Test Plan:
1. Base flow. base=0x100, row_stride=0x40, mac_stride=0x400, num_lines=3, linelen=8, tofifo=fromfifo=1, downstream model busy 3 cycles per line. Required:
   - Three valid pulses.
   - st_addr lanes {0x100,0x500,0x900,0xD00}, then {0x140,...}, then {0x180,...}.
   - tofifo=1,1,0 and fromfifo=0,1,1.
   - done once; busy low after done.
2. Stall: hold ds_ready=1 for 20 cycles after the first command. Required: no second valid until 2 cycles after ds_ready falls; fields unchanged during the stall.
3. Wrap: base=0x1FF0, row_stride=0x20, mac_stride=0x8, 2 lines. Required: lane 3 of line 0 = 0x0008; line 1 lane 0 = 0x0010.
4. Degenerate configs:
   - num_lines=0: done 2 cycles after start, no valid, err=0.
   - linelen=3: done, no valid, err=1; err clears on the next legal start.
5. Start while busy: pulse start with a different base mid-layer. Required: ignored; addresses follow the original base.
6. Reset: assert rst_n=0 in WAIT of line 1 of 4. Required: all outputs 0 next cycle, no further valid, and a new start works normally.
